exe_status_mem_reg: RTL
=======================

# exe_status_mem_reg

Sits directly downstream of the execute-stage ALU. Captures the ALU result and control into the EXE→MEM pipeline register, and owns the architectural NZCV status register. It updates the status register from the ALU status bits on S-suffixed instructions and evaluates the ARM condition field for the instruction in decode. It also feeds the C flag back to the ALU carry input.

## Interface
Parameters:
- WIDTH, 32, datapath width of result and store data

Ports:
- clk  in  1  rising-edge clock; the block uses one clock only
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hold all state; memory stall
- flush  in  1  squash the instruction currently in EXE
- valid_in  in  1  EXE holds a real instruction
- s_bit_in  in  1  instruction updates flags
- status_in  in  4  ALU {N,Z,C,V}
- alu_result_in  in  WIDTH  ALU result / memory address
- val_rm_in  in  WIDTH  store data
- dest_in  in  4  destination register
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control
- cond_in  in  4  condition field of instruction in ID
- status_out  out  4  registered {N,Z,C,V}
- carry_out  out  1  status_out[1], to ALU carry input
- cond_pass  out  1  cond_in satisfied by status_out (combinational)
- flags_pending  out  1  valid_in & s_bit_in & ~flush (combinational)
- valid_out, wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each
- alu_result_out, val_rm_out  out  WIDTH
- dest_out  out  4

## Operation
- Per-edge priority: rst > flush > freeze > normal.
- rst: all registered outputs go to 0, including status_out = 4'b0000 and valid_out = 0.
- flush (freeze is ignored):
  - valid_out, wb_en_out, mem_r_en_out, mem_w_en_out <= 0.
  - alu_result_out, val_rm_out, dest_out <= 0.
  - status register is not updated.
- freeze, no flush: every register holds, status register included.
- Normal: all *_out <= corresponding *_in, valid_out <= valid_in. Control enables are ANDed with valid_in, so an invalid slot is a bubble.
- Status update: status_out <= status_in iff valid_in & s_bit_in & ~flush & ~freeze & ~rst. Otherwise status_out holds.
- cond_pass decode, using the current registered flags with no bypass:
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C
  - 0100 N; 0101 !N; 0110 V; 0111 !V
  - 1000 C&!Z; 1001 !C|Z
  - 1010 N==V; 1011 N!=V
  - 1100 !Z&(N==V); 1101 Z|(N!=V)
  - 1110 1; 1111 0
- flags_pending tells the hazard unit that a flag write is in flight. The hazard unit stalls a conditional instruction in ID; this block does no stalling itself.

## Timing
- EXE→MEM latency: 1 cycle. Inputs sampled at edge k appear on outputs after edge k.
- Flag latency: the S instruction sampled at edge k changes status_out after edge k. An instruction in ID in cycle k+1 sees the new flags via cond_pass and carry_out.
- cond_pass, carry_out and flags_pending are purely combinational from current state and inputs, with no registered delay.
- Reset mid-operation wins over flush/freeze in the same cycle. The first post-reset edge behaves normally.
- freeze held for N cycles keeps outputs stable for N cycles. On release, the pending inputs are captured at the next edge.
- flush and freeze together: flush applies, the bubble enters MEM, and the flags are not written.

## Test plan
- Reset: hold rst for 2 cycles with all inputs nonzero -> all outputs 0; cond_in=4'b1110 gives cond_pass=1; cond_in=4'b0000 gives cond_pass=0.
- Flag update: valid_in=1, s_bit_in=1, status_in=4'b0110 -> next cycle status_out=4'b0110 and carry_out=1. Then s_bit_in=0 with status_in=4'b1001 -> status_out stays 4'b0110.
- Condition sweep: load flags N=1,Z=0,C=1,V=0 and drive all 16 cond_in values -> cond_pass=1 for 0001,0010,0100,0111,1000,1011,1101,1110 and 0 for the rest.
- Freeze: alu_result_in=32'hDEADBEEF captured, then freeze=1 for 3 cycles with alu_result_in=32'h12345678 and an S update -> outputs and status unchanged for all 3 cycles. Released -> 32'h12345678 and the new flags appear after the next edge.
- Flush: valid_in=1, s_bit_in=1, wb_en_in=1, mem_w_en_in=1, flush=1 (also freeze=1) -> next cycle valid_out=0, wb_en_out=0, mem_w_en_out=0, alu_result_out=0, status_out unchanged; flags_pending=0 while flush is high.
- Invalid slot: valid_in=0, wb_en_in=1, s_bit_in=1 -> wb_en_out=0, flags unchanged, flags_pending=0.

Source files
------------

// File: rtl/exe_status_mem_reg_if.sv
// EXE->MEM pipeline bundle: ALU result and control in, registered copies
// plus the NZCV status, condition check and flag-hazard hint out.
interface exe_status_mem_reg_if #(
  parameter int WIDTH = 32
);
  logic             freeze;
  logic             flush;
  logic             valid_in;
  logic             s_bit_in;
  logic [3:0]       status_in;
  logic [WIDTH-1:0] alu_result_in;
  logic [WIDTH-1:0] val_rm_in;
  logic [3:0]       dest_in;
  logic             wb_en_in;
  logic             mem_r_en_in;
  logic             mem_w_en_in;
  logic [3:0]       cond_in;

  logic [3:0]       status_out;
  logic             carry_out;
  logic             cond_pass;
  logic             flags_pending;
  logic             valid_out;
  logic             wb_en_out;
  logic             mem_r_en_out;
  logic             mem_w_en_out;
  logic [WIDTH-1:0] alu_result_out;
  logic [WIDTH-1:0] val_rm_out;
  logic [3:0]       dest_out;

  // The pipeline register itself.
  modport slave (
    input  freeze, flush, valid_in, s_bit_in, status_in, alu_result_in,
           val_rm_in, dest_in, wb_en_in, mem_r_en_in, mem_w_en_in, cond_in,
    output status_out, carry_out, cond_pass, flags_pending, valid_out,
           wb_en_out, mem_r_en_out, mem_w_en_out, alu_result_out,
           val_rm_out, dest_out
  );

  // The execute stage, decode stage and hazard unit driving it.
  modport master (
    output freeze, flush, valid_in, s_bit_in, status_in, alu_result_in,
           val_rm_in, dest_in, wb_en_in, mem_r_en_in, mem_w_en_in, cond_in,
    input  status_out, carry_out, cond_pass, flags_pending, valid_out,
           wb_en_out, mem_r_en_out, mem_w_en_out, alu_result_out,
           val_rm_out, dest_out
  );
endinterface

// File: rtl/exe_status_mem_reg.sv
// EXE->MEM pipeline register that also owns the architectural NZCV flags
// and evaluates the ARM condition field of the instruction in decode.
module exe_status_mem_reg #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  exe_status_mem_reg_if.slave bus
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  logic [3:0]       status_q;
  logic             valid_q, wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [WIDTH-1:0] alu_result_q, val_rm_q;
  logic [3:0]       dest_q;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q     <= 4'b0000;
      valid_q      <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      alu_result_q <= '0;
      val_rm_q     <= '0;
      dest_q       <= 4'd0;
    end else if (bus.flush) begin
      // Bubble into MEM; the squashed instruction never touches the flags.
      valid_q      <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      alu_result_q <= '0;
      val_rm_q     <= '0;
      dest_q       <= 4'd0;
    end else if (!bus.freeze) begin
      valid_q      <= bus.valid_in;
      wb_en_q      <= bus.wb_en_in    & bus.valid_in;
      mem_r_en_q   <= bus.mem_r_en_in & bus.valid_in;
      mem_w_en_q   <= bus.mem_w_en_in & bus.valid_in;
      alu_result_q <= bus.alu_result_in;
      val_rm_q     <= bus.val_rm_in;
      dest_q       <= bus.dest_in;
      if (bus.valid_in && bus.s_bit_in) status_q <= bus.status_in;
    end
  end

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = status_q;

  logic pass;

  // NOTE: pass gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pass = 1'b0;
    unique case (cond_e'(bus.cond_in))
      COND_EQ: pass = flag_z;
      COND_NE: pass = !flag_z;
      COND_CS: pass = flag_c;
      COND_CC: pass = !flag_c;
      COND_MI: pass = flag_n;
      COND_PL: pass = !flag_n;
      COND_VS: pass = flag_v;
      COND_VC: pass = !flag_v;
      COND_HI: pass = flag_c && !flag_z;
      COND_LS: pass = !flag_c || flag_z;
      COND_GE: pass = (flag_n == flag_v);
      COND_LT: pass = (flag_n != flag_v);
      COND_GT: pass = !flag_z && (flag_n == flag_v);
      COND_LE: pass = flag_z || (flag_n != flag_v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

  // Decode reads the registered flags directly; the hazard unit covers the
  // in-flight S instruction via flags_pending.
  assign bus.cond_pass      = pass;
  assign bus.flags_pending  = bus.valid_in & bus.s_bit_in & ~bus.flush;
  assign bus.status_out     = status_q;
  assign bus.carry_out      = flag_c;
  assign bus.valid_out      = valid_q;
  assign bus.wb_en_out      = wb_en_q;
  assign bus.mem_r_en_out   = mem_r_en_q;
  assign bus.mem_w_en_out   = mem_w_en_q;
  assign bus.alu_result_out = alu_result_q;
  assign bus.val_rm_out     = val_rm_q;
  assign bus.dest_out       = dest_q;

endmodule
